// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-stream header splitter.
// Header vector width is derived from beat count and bytes per beat.
package axis_hdr_pkg;

  typedef enum logic [0:0] {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  function automatic int header_width(input int beats, input int bytes);
    return beats * bytes * 8;
  endfunction

  localparam int HEADER_W_DEFAULT = header_width(4, 1);
  typedef logic [HEADER_W_DEFAULT-1:0] header_t;

  function automatic logic [7:0] clamp_beats(input logic [7:0] beats, input logic [7:0] max_beats);
    logic [7:0] r;
    if (beats > max_beats) begin
      r = max_beats;
    end else begin
      r = beats;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_hdr_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured headers.
// Push while full is accepted only when a pop happens in the same cycle.
module axis_hdr_fifo
  import axis_hdr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axis_header_splitter.sv
// Strips a per-packet header off an AXI stream and presents it beside the payload.
// Optional statistics counters are enabled with AXIS_HEADER_SPLITTER_STATS_EN.
module axis_header_splitter
  import axis_hdr_pkg::*;
#(
  parameter int AXIS_BYTES        = 1,
  parameter int AXIS_USER_BITS    = 1,
  parameter int MAX_HEADER_BEATS  = 4,
  parameter int HEADER_FIFO_DEPTH = 2
) (
  input  logic                                                    clk,
  input  logic                                                    areset,
  input  logic [7:0]                                              hdr_beats,
  input  logic                                                    axis_i_tvalid,
  output logic                                                    axis_i_tready,
  input  logic                                                    axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]                                   axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0]                                 axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]                               axis_i_tuser,
  output logic                                                    axis_o_tvalid,
  input  logic                                                    axis_o_tready,
  output logic                                                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]                                   axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0]                                 axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]                               axis_o_tuser,
  output logic [header_width(MAX_HEADER_BEATS, AXIS_BYTES)-1:0]   axis_o_header,
  output logic                                                    runt_pulse
`ifdef AXIS_HEADER_SPLITTER_STATS_EN
  ,
  output logic [31:0]                                             pkt_count,
  output logic [15:0]                                             runt_count
`endif
);

  localparam int              DW    = 8 * AXIS_BYTES;
  localparam int              HW    = header_width(MAX_HEADER_BEATS, AXIS_BYTES);
  localparam int              BW    = 1 + AXIS_USER_BITS + AXIS_BYTES + DW;
  localparam logic [7:0]      MAX_N = 8'(MAX_HEADER_BEATS);

  state_e          state_r;
  logic [7:0]      beat_cnt_r;
  logic [7:0]      n_r;
  logic            ready_en_r;
  logic            runt_pulse_r;
  logic [HW-1:0]   hdr_r;
  logic [HW-1:0]   hdr_next_s;
  logic [HW-1:0]   push_data_s;
  logic [BW-1:0]   in_beat_s;
  logic [BW-1:0]   o_beat_r;
  logic [BW-1:0]   s_beat_r;
  logic            o_valid_r;
  logic            s_valid_r;
  logic [7:0]      n_first_s;
  logic [7:0]      n_cur_s;
  logic            passthru_s;
  logic            in_ready_s;
  logic            in_fire_s;
  logic            hdr_fire_s;
  logic            hdr_done_s;
  logic            runt_s;
  logic            load_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  assign in_beat_s  = {axis_i_tlast, axis_i_tuser, axis_i_tkeep, axis_i_tdata};
  assign n_first_s  = clamp_beats(hdr_beats, MAX_N);
  assign n_cur_s    = (beat_cnt_r == 8'd0) ? n_first_s : n_r;
  // A zero-length header turns the first beat itself into payload.
  assign passthru_s = (state_r == HEADER) && (beat_cnt_r == 8'd0) && (n_first_s == 8'd0);

  // Input acceptance: header beats wait on FIFO space, payload beats on skid space
  always_comb begin
    in_ready_s = 1'b0;
    if (!ready_en_r) begin
      in_ready_s = 1'b0;
    end else if (state_r == PAYLOAD) begin
      in_ready_s = !s_valid_r;
    end else if (passthru_s) begin
      in_ready_s = !fifo_full_s && !s_valid_r;
    end else begin
      in_ready_s = !fifo_full_s;
    end
  end

  assign in_fire_s   = axis_i_tvalid && in_ready_s;
  assign hdr_fire_s  = in_fire_s && (state_r == HEADER) && !passthru_s;
  assign runt_s      = hdr_fire_s && axis_i_tlast;
  assign hdr_done_s  = hdr_fire_s && !axis_i_tlast && (beat_cnt_r == (n_cur_s - 8'd1));
  assign load_s      = in_fire_s && ((state_r == PAYLOAD) || passthru_s);
  assign push_s      = hdr_done_s || (in_fire_s && passthru_s);
  assign push_data_s = passthru_s ? '0 : hdr_next_s;
  assign pop_s       = o_valid_r && axis_o_tready && o_beat_r[BW-1];

  // Header assembly: current beat into its slice, slices past the header length zeroed
  always_comb begin
    hdr_next_s = hdr_r;
    for (int i = 0; i < MAX_HEADER_BEATS; i++) begin
      if (8'(i) == beat_cnt_r) begin
        hdr_next_s[i*DW +: DW] = axis_i_tdata;
      end else if (8'(i) >= n_cur_s) begin
        hdr_next_s[i*DW +: DW] = '0;
      end else begin
        hdr_next_s[i*DW +: DW] = hdr_r[i*DW +: DW];
      end
    end
  end

  // Packet framing FSM with beat counter and runt flag
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r      <= HEADER;
      beat_cnt_r   <= 8'd0;
      n_r          <= 8'd0;
      hdr_r        <= '0;
      ready_en_r   <= 1'b0;
      runt_pulse_r <= 1'b0;
    end else begin
      ready_en_r   <= 1'b1;
      runt_pulse_r <= runt_s;
      if (hdr_fire_s && (beat_cnt_r == 8'd0)) begin
        n_r <= n_first_s;
      end
      if (hdr_fire_s) begin
        hdr_r <= hdr_next_s;
      end
      case (state_r)
        HEADER: begin
          if (runt_s) begin
            beat_cnt_r <= 8'd0;
          end else if (hdr_done_s) begin
            beat_cnt_r <= 8'd0;
            state_r    <= PAYLOAD;
          end else if (hdr_fire_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
          end else if (in_fire_s && passthru_s && !axis_i_tlast) begin
            state_r <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (in_fire_s && axis_i_tlast) begin
            state_r    <= HEADER;
            beat_cnt_r <= 8'd0;
          end
        end
        default: begin
          state_r    <= HEADER;
          beat_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Two-entry skid stage: output register plus overflow register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      o_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      o_beat_r  <= '0;
      s_beat_r  <= '0;
    end else if (axis_o_tready || !o_valid_r) begin
      if (s_valid_r) begin
        o_beat_r  <= s_beat_r;
        o_valid_r <= 1'b1;
        s_valid_r <= 1'b0;
      end else begin
        o_beat_r  <= in_beat_s;
        o_valid_r <= load_s;
      end
    end else if (load_s) begin
      s_beat_r  <= in_beat_s;
      s_valid_r <= 1'b1;
    end
  end

  axis_hdr_fifo #(
    .DEPTH (HEADER_FIFO_DEPTH),
    .WIDTH (HW)
  ) u_hdr_fifo (
    .clk       (clk),
    .rst       (areset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (axis_o_header),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign axis_i_tready = in_ready_s;
  assign axis_o_tvalid = o_valid_r;
  assign {axis_o_tlast, axis_o_tuser, axis_o_tkeep, axis_o_tdata} = o_beat_r;
  assign runt_pulse    = runt_pulse_r;

`ifdef AXIS_HEADER_SPLITTER_STATS_EN
  logic [31:0] pkt_count_r;
  logic [15:0] runt_count_r;

  // Saturating packet and runt counters
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pkt_count_r  <= 32'd0;
      runt_count_r <= 16'd0;
    end else begin
      if (pop_s && (pkt_count_r != 32'hFFFF_FFFF)) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if (runt_pulse_r && (runt_count_r != 16'hFFFF)) begin
        runt_count_r <= runt_count_r + 16'd1;
      end
    end
  end

  assign pkt_count  = pkt_count_r;
  assign runt_count = runt_count_r;
`endif

endmodule

// File: tb/tb_axis_header_splitter.sv
// Directed self-checking bench for axis_header_splitter (default parameters).
module tb_axis_header_splitter;

  localparam int HW = 32;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [7:0]    hdr_beats = 8'd0;
  logic          axis_i_tvalid = 1'b0;
  logic          axis_i_tready;
  logic          axis_i_tlast = 1'b0;
  logic [0:0]    axis_i_tkeep = 1'b1;
  logic [7:0]    axis_i_tdata = 8'h00;
  logic [0:0]    axis_i_tuser = 1'b0;
  logic          axis_o_tvalid;
  logic          axis_o_tready = 1'b0;
  logic          axis_o_tlast;
  logic [0:0]    axis_o_tkeep;
  logic [7:0]    axis_o_tdata;
  logic [0:0]    axis_o_tuser;
  logic [HW-1:0] axis_o_header;
  logic          runt_pulse;

  int checks = 0;
  int errors = 0;

  logic [7:0]    out_data [$];
  logic          out_last [$];
  logic [1:0]    out_ku   [$];
  logic [HW-1:0] out_hdr  [$];
  int            out_cyc  [$];
  int            cyc = 0;
  int            runt_total = 0;
  int            runt_run = 0;
  int            runt_max = 0;

  always #5 clk = ~clk;

  axis_header_splitter dut (
    .clk           (clk),
    .areset        (areset),
    .hdr_beats     (hdr_beats),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tready (axis_i_tready),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tkeep  (axis_i_tkeep),
    .axis_i_tdata  (axis_i_tdata),
    .axis_i_tuser  (axis_i_tuser),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tready (axis_o_tready),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tkeep  (axis_o_tkeep),
    .axis_o_tdata  (axis_o_tdata),
    .axis_o_tuser  (axis_o_tuser),
    .axis_o_header (axis_o_header),
    .runt_pulse    (runt_pulse)
  );

  // Output/runt monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (axis_o_tvalid && axis_o_tready) begin
      out_data.push_back(axis_o_tdata);
      out_last.push_back(axis_o_tlast);
      out_ku.push_back({axis_o_tuser, axis_o_tkeep});
      out_hdr.push_back(axis_o_header);
      out_cyc.push_back(cyc);
    end
    if (runt_pulse) begin
      if (runt_run == 0) runt_total++;
      runt_run++;
      if (runt_run > runt_max) runt_max = runt_run;
    end else begin
      runt_run = 0;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic [7:0] hb, output int tries);
    bit ok = 1'b0;
    tries = 0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = d;
    axis_i_tlast  = l;
    axis_i_tkeep  = 1'b1;
    axis_i_tuser  = d[0];
    hdr_beats     = hb;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = axis_i_tready;
      @(posedge clk);
      #1;
      tries++;
    end
    axis_i_tvalid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: data %0h not accepted, tready=%0b expected 1", d, axis_i_tready);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (axis_o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", axis_o_tvalid); end
    checks++; if (axis_i_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b expected 0", axis_i_tready); end
    checks++; if (runt_pulse !== 1'b0) begin errors++; $display("FAIL reset_runt: got %0b expected 0", runt_pulse); end
    checks++; if (axis_o_header !== 32'h0) begin errors++; $display("FAIL reset_header: got %0h expected 0", axis_o_header); end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (axis_i_tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %0b expected 1", axis_i_tready); end
  endtask

  task automatic test_basic();
    logic [7:0] in_d [5] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03};
    logic [1:0] exp_ku [3] = '{2'b11, 2'b01, 2'b11};
    int base;
    int t;
    axis_o_tready = 1'b1;
    base = out_data.size();
    for (int i = 0; i < 5; i++) send_beat(in_d[i], (i == 4), 8'd2, t);
    wait_cycles(4);
    checks++; if (out_data.size() - base !== 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", out_data.size() - base); end
    if (out_data.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (out_data[base+i] !== 8'(i + 1)) begin errors++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, out_data[base+i], i + 1); end
        checks++; if (out_last[base+i] !== (i == 2)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", i, out_last[base+i], (i == 2)); end
        checks++; if (out_ku[base+i] !== exp_ku[i]) begin errors++; $display("FAIL basic_user_keep[%0d]: got %0b expected %0b", i, out_ku[base+i], exp_ku[i]); end
        checks++; if (out_hdr[base+i] !== 32'h0000BBAA) begin errors++; $display("FAIL basic_header[%0d]: got %0h expected 0000bbaa", i, out_hdr[base+i]); end
      end
    end
  endtask

  task automatic test_passthru();
    int base;
    int t;
    int tot = 0;
    base = out_data.size();
    send_beat(8'h11, 1'b0, 8'd0, t); tot += t;
    send_beat(8'h22, 1'b1, 8'd0, t); tot += t;
    wait_cycles(3);
    checks++; if (tot !== 2) begin errors++; $display("FAIL passthru_stall: got %0d accept cycles expected 2", tot); end
    checks++; if (out_data.size() - base !== 2) begin errors++; $display("FAIL passthru_count: got %0d expected 2", out_data.size() - base); end
    if (out_data.size() - base >= 2) begin
      checks++; if (out_data[base] !== 8'h11 || out_data[base+1] !== 8'h22) begin errors++; $display("FAIL passthru_data: got %0h %0h expected 11 22", out_data[base], out_data[base+1]); end
      checks++; if (out_last[base] !== 1'b0 || out_last[base+1] !== 1'b1) begin errors++; $display("FAIL passthru_last: got %0b %0b expected 0 1", out_last[base], out_last[base+1]); end
      checks++; if (out_hdr[base] !== 32'h0 || out_hdr[base+1] !== 32'h0) begin errors++; $display("FAIL passthru_header: got %0h %0h expected 0 0", out_hdr[base], out_hdr[base+1]); end
    end
  endtask

  task automatic test_runt();
    int base;
    int r0;
    int t;
    base = out_data.size();
    r0 = runt_total;
    send_beat(8'hAA, 1'b0, 8'd3, t);
    send_beat(8'hBB, 1'b1, 8'd3, t);
    wait_cycles(3);
    checks++; if (out_data.size() !== base) begin errors++; $display("FAIL runt_no_output: got %0d beats expected 0", out_data.size() - base); end
    checks++; if (runt_total - r0 !== 1) begin errors++; $display("FAIL runt_pulse_count: got %0d expected 1", runt_total - r0); end
    checks++; if (runt_max !== 1) begin errors++; $display("FAIL runt_pulse_width: got %0d cycles expected 1", runt_max); end
    send_beat(8'hCC, 1'b0, 8'd1, t);
    send_beat(8'h05, 1'b1, 8'd1, t);
    wait_cycles(3);
    checks++; if (out_data.size() - base !== 1) begin errors++; $display("FAIL runt_next_count: got %0d expected 1", out_data.size() - base); end
    if (out_data.size() - base >= 1) begin
      checks++; if (out_data[base] !== 8'h05 || out_last[base] !== 1'b1) begin errors++; $display("FAIL runt_next_data: got %0h/%0b expected 05/1", out_data[base], out_last[base]); end
      checks++; if (out_hdr[base] !== 32'h000000CC) begin errors++; $display("FAIL runt_next_header: got %0h expected 000000cc", out_hdr[base]); end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] in_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int base;
    int t;
    base = out_data.size();
    for (int i = 0; i < 5; i++) send_beat(in_d[i], (i == 4), 8'd9, t);
    wait_cycles(3);
    checks++; if (out_data.size() - base !== 1) begin errors++; $display("FAIL clamp_count: got %0d expected 1", out_data.size() - base); end
    if (out_data.size() - base >= 1) begin
      checks++; if (out_data[base] !== 8'h55) begin errors++; $display("FAIL clamp_data: got %0h expected 55", out_data[base]); end
      checks++; if (out_hdr[base] !== 32'h44332211) begin errors++; $display("FAIL clamp_header: got %0h expected 44332211", out_hdr[base]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int t;
    int tot = 0;
    int bubbles = 0;
    base = out_data.size();
    for (int p = 0; p < 3; p++) begin
      send_beat(8'(8'hB0 + p), 1'b0, 8'd1, t); tot += t;
      for (int j = 0; j < 3; j++) begin
        send_beat(8'(8'h40 + p * 4 + j), (j == 2), 8'd1, t); tot += t;
      end
    end
    wait_cycles(4);
    checks++; if (tot !== 12) begin errors++; $display("FAIL b2b_input_cycles: got %0d expected 12", tot); end
    checks++; if (out_data.size() - base !== 9) begin errors++; $display("FAIL b2b_count: got %0d expected 9", out_data.size() - base); end
    if (out_data.size() - base >= 9) begin
      for (int p = 0; p < 3; p++) begin
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (out_data[base+p*3+j] !== 8'(8'h40 + p * 4 + j) || out_hdr[base+p*3+j] !== 32'(8'hB0 + p) ||
              out_last[base+p*3+j] !== (j == 2)) begin
            errors++;
            $display("FAIL b2b_beat[%0d.%0d]: got %0h/%0h/%0b expected %0h/%0h/%0b", p, j, out_data[base+p*3+j],
                     out_hdr[base+p*3+j], out_last[base+p*3+j], 8'h40 + p * 4 + j, 8'hB0 + p, (j == 2));
          end
          if (j > 0 && out_cyc[base+p*3+j] - out_cyc[base+p*3+j-1] != 1) bubbles++;
        end
      end
      checks++; if (bubbles !== 0) begin errors++; $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); end
      checks++; if (out_cyc[base+3] - out_cyc[base] !== 4) begin errors++; $display("FAIL b2b_period: got %0d expected 4", out_cyc[base+3] - out_cyc[base]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [3] = '{8'h31, 8'h41, 8'h51};
    logic [7:0] exp_h [3] = '{8'hA1, 8'hA2, 8'hA3};
    int base;
    int t;
    int tot = 0;
    bit stalled = 1'b1;
    axis_o_tready = 1'b0;
    base = out_data.size();
    send_beat(8'hA1, 1'b0, 8'd1, t); tot += t;
    send_beat(8'h31, 1'b1, 8'd1, t); tot += t;
    send_beat(8'hA2, 1'b0, 8'd1, t); tot += t;
    send_beat(8'h41, 1'b1, 8'd1, t); tot += t;
    checks++; if (tot !== 4) begin errors++; $display("FAIL bp_two_headers: got %0d accept cycles expected 4", tot); end
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = 8'hA3;
    axis_i_tlast  = 1'b0;
    hdr_beats     = 8'd1;
    repeat (4) begin
      @(negedge clk);
      if (axis_i_tready) stalled = 1'b0;
    end
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL bp_third_header_stall: got %0b expected 1", stalled); end
    checks++; if (axis_o_tvalid !== 1'b1 || axis_o_header !== 32'h000000A1) begin errors++; $display("FAIL bp_held_header: got %0b/%0h expected 1/000000a1", axis_o_tvalid, axis_o_header); end
    @(posedge clk);
    #1;
    axis_o_tready = 1'b1;
    send_beat(8'hA3, 1'b0, 8'd1, t);
    send_beat(8'h51, 1'b1, 8'd1, t);
    wait_cycles(5);
    checks++; if (out_data.size() - base !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", out_data.size() - base); end
    if (out_data.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_data[base+i] !== exp_d[i] || out_hdr[base+i] !== 32'(exp_h[i]) || out_last[base+i] !== 1'b1) begin
          errors++;
          $display("FAIL bp_pkt[%0d]: got %0h/%0h/%0b expected %0h/%0h/1", i, out_data[base+i], out_hdr[base+i], out_last[base+i], exp_d[i], exp_h[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int t;
    axis_o_tready = 1'b0;
    send_beat(8'hC0, 1'b0, 8'd1, t);
    send_beat(8'h61, 1'b0, 8'd1, t);
    send_beat(8'h62, 1'b0, 8'd1, t);
    checks++; if (axis_o_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre_tvalid: got %0b expected 1", axis_o_tvalid); end
    #2;
    areset = 1'b1;
    #1;
    checks++; if (axis_o_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %0b expected 0", axis_o_tvalid); end
    checks++; if (axis_i_tready !== 1'b0 || axis_o_header !== 32'h0) begin errors++; $display("FAIL midrst_state: got %0b/%0h expected 0/0", axis_i_tready, axis_o_header); end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    axis_o_tready = 1'b1;
    base = out_data.size();
    send_beat(8'hD1, 1'b0, 8'd2, t);
    send_beat(8'hD2, 1'b0, 8'd2, t);
    send_beat(8'h71, 1'b0, 8'd2, t);
    send_beat(8'h72, 1'b1, 8'd2, t);
    wait_cycles(4);
    checks++; if (out_data.size() - base !== 2) begin errors++; $display("FAIL midrst_count: got %0d expected 2", out_data.size() - base); end
    if (out_data.size() - base >= 2) begin
      checks++; if (out_data[base] !== 8'h71 || out_data[base+1] !== 8'h72) begin errors++; $display("FAIL midrst_data: got %0h %0h expected 71 72", out_data[base], out_data[base+1]); end
      checks++; if (out_hdr[base] !== 32'h0000D2D1 || out_hdr[base+1] !== 32'h0000D2D1) begin errors++; $display("FAIL midrst_header: got %0h %0h expected 0000d2d1", out_hdr[base], out_hdr[base+1]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_passthru();
    test_runt();
    test_clamp();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
